// File: rtl/i2c_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2c_slave_pkg
// Brief   : Shared state encoding and bus-level constants for the I2C target.
// Revision: 1.0
// ============================================================================
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8
    } state_t;

    localparam logic c_RW_READ = 1'b1;
    localparam logic c_ACK     = 1'b0;
    localparam logic c_NACK    = 1'b1;

    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] slave_addr);
        return (addr_byte[7:1] == slave_addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : i2c_slave_if
// Brief   : Pin-side and register-port signals of the I2C target.
// Revision: 1.0
// ============================================================================
interface i2c_slave_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );

    modport master (
        output scl_in, sda_in, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_line_sync.sv
`default_nettype none
// ============================================================================
// Module  : i2c_slave_line_sync
// Brief   : 2-FF synchroniser plus edge and START/STOP detection for SCL/SDA.
// Revision: 1.0
// ============================================================================
module i2c_slave_line_sync (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic scl_in,
    input  wire logic sda_in,
    output logic      scl,
    output logic      sda,
    output logic      scl_rise,
    output logic      scl_fall,
    output logic      start_det,
    output logic      stop_det
);
    // [0] metastable stage, [1] synchronised, [2] one-clk delayed copy
    logic [2:0] r_scl_pipe;
    logic [2:0] r_sda_pipe;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scl_pipe <= 3'b111;
            r_sda_pipe <= 3'b111;
        end else begin
            r_scl_pipe <= {r_scl_pipe[1:0], scl_in};
            r_sda_pipe <= {r_sda_pipe[1:0], sda_in};
        end
    end

    assign scl       = r_scl_pipe[1];
    assign sda       = r_sda_pipe[1];
    assign scl_rise  =  r_scl_pipe[1] & ~r_scl_pipe[2];
    assign scl_fall  = ~r_scl_pipe[1] &  r_scl_pipe[2];
    assign start_det =  r_scl_pipe[1] &  r_scl_pipe[2] &  r_sda_pipe[2] & ~r_sda_pipe[1];
    assign stop_det  =  r_scl_pipe[1] &  r_scl_pipe[2] & ~r_sda_pipe[2] &  r_sda_pipe[1];
endmodule
`default_nettype wire

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module  : i2c_slave
// Brief   : Oversampling I2C target bridging bus bytes to a byte register port.
// Revision: 1.0
// ============================================================================
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  wire logic  clk,
    input  wire logic  reset,
    i2c_slave_if.slave bus
);
    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_slave_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .scl       (w_scl),
        .sda       (w_sda),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    state_t     r_state, w_state_next;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic       r_full, w_full_next;
    logic [7:0] r_shift, w_shift_next;
    logic [7:0] r_addr, w_addr_next;
    logic [7:0] r_wdata, w_wdata_next;
    logic       r_oe, w_oe_next;
    logic       r_wr, w_wr_next;
    logic       r_rd, w_rd_next;
    logic       r_busy, w_busy_next;
    logic       r_mack, w_mack_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_full    <= 1'b0;
            r_shift   <= 8'h00;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_oe      <= 1'b0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_busy    <= 1'b0;
            r_mack    <= c_NACK;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_full    <= w_full_next;
            r_shift   <= w_shift_next;
            r_addr    <= w_addr_next;
            r_wdata   <= w_wdata_next;
            r_oe      <= w_oe_next;
            r_wr      <= w_wr_next;
            r_rd      <= w_rd_next;
            r_busy    <= w_busy_next;
            r_mack    <= w_mack_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_full_next    = r_full;
        w_shift_next   = r_shift;
        w_addr_next    = r_addr;
        w_wdata_next   = r_wdata;
        w_oe_next      = r_oe;
        w_wr_next      = 1'b0;
        w_rd_next      = 1'b0;
        w_busy_next    = r_busy;
        w_mack_next    = r_mack;

        // Pointer advances one clk after each register strobe
        if (r_wr || r_rd) begin
            w_addr_next = r_addr + 8'd1;
        end

        case (r_state)
            ST_IDLE: begin
                w_busy_next = 1'b0;
            end
            ST_ADDR, ST_PTR, ST_WDATA: begin
                if (w_scl_rise) begin
                    w_shift_next   = {r_shift[6:0], w_sda};
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_full_next = 1'b1;
                    end
                end else if (w_scl_fall && r_full) begin
                    w_full_next = 1'b0;
                    w_oe_next   = 1'b1;
                    if (r_state == ST_ADDR) begin
                        if (addr_match(r_shift, SLAVE_ADDR)) begin
                            w_state_next = ST_ADDR_ACK;
                            w_busy_next  = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_oe_next    = 1'b0;
                        end
                    end else if (r_state == ST_PTR) begin
                        w_addr_next  = r_shift;
                        w_state_next = ST_PTR_ACK;
                    end else begin
                        w_state_next = ST_WDATA_ACK;
                    end
                end
            end
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                if (w_scl_fall) begin
                    w_oe_next      = 1'b0;
                    w_bit_cnt_next = 3'd0;
                    if (r_state == ST_ADDR_ACK) begin
                        if (r_shift[0] == c_RW_READ) begin
                            w_rd_next    = 1'b1;
                            w_state_next = ST_RDATA;
                        end else begin
                            w_state_next = ST_PTR;
                        end
                    end else begin
                        if (r_state == ST_WDATA_ACK) begin
                            w_wdata_next = r_shift;
                            w_wr_next    = 1'b1;
                        end
                        w_state_next = ST_WDATA;
                    end
                end
            end
            ST_RDATA: begin
                // The strobe cycle is when reg_rdata is valid; drive its MSB immediately
                if (r_rd) begin
                    w_shift_next   = bus.reg_rdata;
                    w_oe_next      = ~bus.reg_rdata[7];
                    w_bit_cnt_next = 3'd0;
                end else if (w_scl_fall) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_oe_next    = 1'b0;
                        w_state_next = ST_RACK;
                    end else begin
                        w_shift_next   = {r_shift[6:0], 1'b0};
                        w_oe_next      = ~r_shift[6];
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_RACK: begin
                if (w_scl) begin
                    w_mack_next = w_sda;
                end
                if (w_scl_fall) begin
                    if (r_mack == c_ACK) begin
                        w_rd_next    = 1'b1;
                        w_state_next = ST_RDATA;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_busy_next  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_oe_next    = 1'b0;
            end
        endcase

        // Bus conditions override whatever the current state decided
        if (w_start) begin
            w_state_next   = ST_ADDR;
            w_bit_cnt_next = 3'd0;
            w_full_next    = 1'b0;
            w_oe_next      = 1'b0;
        end else if (w_stop) begin
            w_state_next = ST_IDLE;
            w_full_next  = 1'b0;
            w_oe_next    = 1'b0;
            w_busy_next  = 1'b0;
        end
    end

    assign bus.sda_oe    = r_oe;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_wr    = r_wr;
    assign bus.reg_rd    = r_rd;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_slave
// Brief   : Directed bus-master stimulus and checks for i2c_slave.
// Revision: 1.0
// ============================================================================
module tb_i2c_slave;
    import i2c_slave_pkg::*;

    localparam int c_Q = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic [7:0] mem [256];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    i2c_slave_if bus ();

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.scl_in    = m_scl;
    assign bus.sda_in    = m_sda & ~bus.sda_oe;
    assign bus.reg_rdata = mem[bus.reg_addr];

    always #5 clk = ~clk;

    // Strobe / activity log
    logic [7:0] wr_a [64];
    logic [7:0] wr_d [64];
    logic [7:0] rd_a [64];
    int wr_n = 0, rd_n = 0, oe_cnt = 0, busy_cnt = 0;

    always @(negedge clk) begin
        if (bus.reg_wr && wr_n < 64) begin
            wr_a[wr_n] = bus.reg_addr;
            wr_d[wr_n] = bus.reg_wdata;
            wr_n++;
        end
        if (bus.reg_rd && rd_n < 64) begin
            rd_a[rd_n] = bus.reg_addr;
            rd_n++;
        end
        if (bus.sda_oe) oe_cnt++;
        if (bus.busy)   busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic qtr();
        repeat (c_Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; qtr();
        m_scl = 1'b1; qtr();
        m_sda = 1'b0; qtr();
        m_scl = 1'b0; qtr();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; qtr();
        m_scl = 1'b1; qtr();
        m_sda = 1'b1; qtr();
        qtr();
    endtask

    task automatic clock_bit(input logic b, output logic s);
        m_sda = b;    qtr();
        m_scl = 1'b1; qtr();
        s = bus.sda_in;
        qtr();
        m_scl = 1'b0; qtr();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(mack, s);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] d;
        int         wr0, rd0, oe0, busy0;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'h3C;

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
        chk("rst_reg_rd", 32'(bus.reg_rd), 32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_addr",   32'(bus.reg_addr),  32'h00);
        chk("rst_wdata",  32'(bus.reg_wdata), 32'h00);
        chk("rst_state",  32'(dut.r_state),   32'(ST_IDLE));
        reset = 1'b1;
        qtr();

        // 1: pointer 0x10, burst write AB, CD
        wr0 = wr_n;
        bus_start();
        write_byte(8'hA0, ack); chk("t1_ack_addr", 32'(ack), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        write_byte(8'h10, ack); chk("t1_ack_ptr", 32'(ack), 32'd0);
        write_byte(8'hAB, ack); chk("t1_ack_d0", 32'(ack), 32'd0);
        write_byte(8'hCD, ack); chk("t1_ack_d1", 32'(ack), 32'd0);
        bus_stop();
        chk("t1_wr_count", 32'(wr_n - wr0), 32'd2);
        chk("t1_wr0_addr", 32'(wr_a[wr0]),   32'h10);
        chk("t1_wr0_data", 32'(wr_d[wr0]),   32'hAB);
        chk("t1_wr1_addr", 32'(wr_a[wr0+1]), 32'h11);
        chk("t1_wr1_data", 32'(wr_d[wr0+1]), 32'hCD);
        chk("t1_addr_end", 32'(bus.reg_addr), 32'h12);
        chk("t1_busy_end", 32'(bus.busy), 32'd0);

        // 2: wrong address 0x51 is ignored
        wr0 = wr_n; rd0 = rd_n; oe0 = oe_cnt; busy0 = busy_cnt;
        bus_start();
        write_byte(8'hA2, ack);
        chk("t2_nack",     32'(ack), 32'd1);
        chk("t2_oe_seen",  32'(oe_cnt - oe0), 32'd0);
        chk("t2_busy_seen",32'(busy_cnt - busy0), 32'd0);
        chk("t2_no_wr",    32'(wr_n - wr0), 32'd0);
        chk("t2_no_rd",    32'(rd_n - rd0), 32'd0);
        chk("t2_state",    32'(dut.r_state), 32'(ST_IDLE));

        // 3: pointer 0x20, repeated START, read two bytes (ACK then NACK)
        rd0 = rd_n;
        bus_start();
        write_byte(8'hA0, ack); chk("t3_ack_addr", 32'(ack), 32'd0);
        write_byte(8'h20, ack); chk("t3_ack_ptr",  32'(ack), 32'd0);
        bus_start();
        write_byte(8'hA1, ack); chk("t3_ack_raddr", 32'(ack), 32'd0);
        read_byte(d, 1'b0); chk("t3_rd0", 32'(d), 32'h5A);
        read_byte(d, 1'b1); chk("t3_rd1", 32'(d), 32'h3C);
        chk("t3_oe_after_nack", 32'(bus.sda_oe), 32'd0);
        chk("t3_state",    32'(dut.r_state), 32'(ST_IDLE));
        chk("t3_rd_count", 32'(rd_n - rd0), 32'd2);
        chk("t3_rd0_addr", 32'(rd_a[rd0]),   32'h20);
        chk("t3_rd1_addr", 32'(rd_a[rd0+1]), 32'h21);
        bus_stop();

        // 4: pointer wrap FE -> FF -> 00
        wr0 = wr_n;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'hFE, ack);
        write_byte(8'h01, ack);
        write_byte(8'h02, ack);
        write_byte(8'h03, ack); chk("t4_ack_last", 32'(ack), 32'd0);
        bus_stop();
        chk("t4_wr_count", 32'(wr_n - wr0), 32'd3);
        chk("t4_wr0", {16'h0, wr_a[wr0],   wr_d[wr0]},   32'h0000FE01);
        chk("t4_wr1", {16'h0, wr_a[wr0+1], wr_d[wr0+1]}, 32'h0000FF02);
        chk("t4_wr2", {16'h0, wr_a[wr0+2], wr_d[wr0+2]}, 32'h00000003);
        chk("t4_addr_end", 32'(bus.reg_addr), 32'h01);

        // 5: STOP after 5 bits of a data byte
        wr0 = wr_n;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h40, ack);
        for (int i = 0; i < 5; i++) clock_bit(1'b1, s);
        bus_stop();
        chk("t5_no_wr",  32'(wr_n - wr0), 32'd0);
        chk("t5_oe",     32'(bus.sda_oe), 32'd0);
        chk("t5_busy",   32'(bus.busy), 32'd0);
        chk("t5_state",  32'(dut.r_state), 32'(ST_IDLE));
        chk("t5_addr",   32'(bus.reg_addr), 32'h40);

        // 6: reset during the address ACK, then a full write
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            d = 8'hA0;
            clock_bit(d[i], s);
        end
        chk("t6_pre_oe",    32'(bus.sda_oe), 32'd1);
        chk("t6_pre_state", 32'(dut.r_state), 32'(ST_ADDR_ACK));
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_oe",    32'(bus.sda_oe), 32'd0);
        chk("t6_rst_busy",  32'(bus.busy), 32'd0);
        chk("t6_rst_addr",  32'(bus.reg_addr), 32'h00);
        chk("t6_rst_wdata", 32'(bus.reg_wdata), 32'h00);
        chk("t6_rst_strb",  {30'd0, bus.reg_wr, bus.reg_rd}, 32'd0);
        chk("t6_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus_stop();
        wr0 = wr_n;
        bus_start();
        write_byte(8'hA0, ack); chk("t6_ack_addr", 32'(ack), 32'd0);
        write_byte(8'h55, ack);
        write_byte(8'h77, ack); chk("t6_ack_data", 32'(ack), 32'd0);
        bus_stop();
        chk("t6_wr_count", 32'(wr_n - wr0), 32'd1);
        chk("t6_wr", {16'h0, wr_a[wr0], wr_d[wr0]}, 32'h00005577);
        chk("t6_addr_end", 32'(bus.reg_addr), 32'h56);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
